// File: rtl/pic_control_pkg.sv
// Shared definitions for the 8259A control-word sequencer: init-state encoding
// and bit positions inside ICW1, ICW4 and OCW3.
package pic_control_pkg;

    typedef enum logic [2:0] {
        ST_UNINIT    = 3'd0,
        ST_WAIT_ICW2 = 3'd1,
        ST_WAIT_ICW3 = 3'd2,
        ST_WAIT_ICW4 = 3'd3,
        ST_READY     = 3'd4
    } cws_state_t;

    localparam int ICW1_LTIM = 3;
    localparam int ICW1_ADI  = 2;
    localparam int ICW1_SNGL = 1;
    localparam int ICW1_IC4  = 0;

    localparam int ICW4_SFNM = 4;
    localparam int ICW4_BUF  = 3;
    localparam int ICW4_MS   = 2;
    localparam int ICW4_AEOI = 1;
    localparam int ICW4_UPM  = 0;

    localparam int OCW3_ESMM = 6;
    localparam int OCW3_SMM  = 5;
    localparam int OCW3_RR   = 1;
    localparam int OCW3_RIS  = 0;

endpackage

// File: rtl/control_word_sequencer_write_strobe_edge_detector.sv
// Registered rising-edge detector: a level strobe held any number of cycles
// yields a single-cycle pulse in its first high cycle.
module write_strobe_edge_detector (
    input  logic clock,
    input  logic reset,
    input  logic strobe,
    output logic pulse
);

    logic strobe_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            strobe_q <= 1'b0;
        end else begin
            strobe_q <= strobe;
        end
    end

    assign pulse = strobe & ~strobe_q;

endmodule

// File: rtl/control_word_sequencer.sv
// 8259A ICW/OCW sequencer and configuration register file.
// Optional build macro CASCADE_MODE_EN enables the ICW3 step and cascade register.
module control_word_sequencer
    import pic_control_pkg::*;
#(
    parameter logic [7:0] IMR_RESET_VALUE  = 8'h00,
    parameter logic [7:0] ICW3_RESET_VALUE = 8'h00
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] internal_data_bus,
    input  logic       write_initial_command_word_1,
    input  logic       write_a0_high,
    input  logic       write_operation_control_word_2,
    input  logic       write_operation_control_word_3,
    output logic       init_done,
    output logic       level_or_edge_triggered,
    output logic       call_address_interval_4,
    output logic       single_or_cascade,
    output logic [4:0] interrupt_vector_address,
    output logic [7:0] cascade_device_config,
    output logic       special_fully_nested,
    output logic       buffered_mode,
    output logic       buffered_master_or_slave,
    output logic       auto_eoi,
    output logic       u8086_or_mcs80,
    output logic [7:0] interrupt_mask,
    output logic       special_mask_mode,
    output logic       read_register_isr_or_irr,
    output logic       ocw2_strobe,
    output logic [7:0] ocw2_command
);

    logic       icw1_ev;
    logic       a0_ev;
    logic       ocw2_ev;
    logic       ocw3_ev;
    logic       do_icw1;
    logic       do_a0;
    logic       do_ocw2;
    logic       do_ocw3;
    logic       ic4;
    cws_state_t state;
    cws_state_t after_icw2;

    write_strobe_edge_detector u_icw1_edge (
        .clock (clock),
        .reset (reset),
        .strobe(write_initial_command_word_1),
        .pulse (icw1_ev)
    );

    write_strobe_edge_detector u_a0_edge (
        .clock (clock),
        .reset (reset),
        .strobe(write_a0_high),
        .pulse (a0_ev)
    );

    write_strobe_edge_detector u_ocw2_edge (
        .clock (clock),
        .reset (reset),
        .strobe(write_operation_control_word_2),
        .pulse (ocw2_ev)
    );

    write_strobe_edge_detector u_ocw3_edge (
        .clock (clock),
        .reset (reset),
        .strobe(write_operation_control_word_3),
        .pulse (ocw3_ev)
    );

    // Only the highest-priority event of a cycle is acted on; the rest are dropped.
    assign do_icw1 = icw1_ev;
    assign do_a0   = a0_ev & ~icw1_ev;
    assign do_ocw2 = ocw2_ev & ~icw1_ev & ~a0_ev;
    assign do_ocw3 = ocw3_ev & ~icw1_ev & ~a0_ev & ~ocw2_ev;

    always_comb begin
        after_icw2 = ic4 ? ST_WAIT_ICW4 : ST_READY;
`ifdef CASCADE_MODE_EN
        if (!single_or_cascade) begin
            after_icw2 = ST_WAIT_ICW3;
        end
`endif
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state                    <= ST_UNINIT;
            ic4                      <= 1'b0;
            level_or_edge_triggered  <= 1'b0;
            call_address_interval_4  <= 1'b0;
            single_or_cascade        <= 1'b0;
            interrupt_vector_address <= 5'd0;
            special_fully_nested     <= 1'b0;
            buffered_mode            <= 1'b0;
            buffered_master_or_slave <= 1'b0;
            auto_eoi                 <= 1'b0;
            u8086_or_mcs80           <= 1'b0;
            interrupt_mask           <= IMR_RESET_VALUE;
            special_mask_mode        <= 1'b0;
            read_register_isr_or_irr <= 1'b0;
            ocw2_strobe              <= 1'b0;
            ocw2_command             <= 8'h00;
        end else begin
            ocw2_strobe  <= 1'b0;
            ocw2_command <= 8'h00;
            if (do_icw1) begin
                level_or_edge_triggered  <= internal_data_bus[ICW1_LTIM];
                call_address_interval_4  <= internal_data_bus[ICW1_ADI];
                single_or_cascade        <= internal_data_bus[ICW1_SNGL];
                ic4                      <= internal_data_bus[ICW1_IC4];
                interrupt_mask           <= IMR_RESET_VALUE;
                special_mask_mode        <= 1'b0;
                read_register_isr_or_irr <= 1'b0;
                special_fully_nested     <= 1'b0;
                buffered_mode            <= 1'b0;
                buffered_master_or_slave <= 1'b0;
                auto_eoi                 <= 1'b0;
                u8086_or_mcs80           <= 1'b0;
                state                    <= ST_WAIT_ICW2;
            end else if (do_a0) begin
                case (state)
                    ST_WAIT_ICW2: begin
                        interrupt_vector_address <= internal_data_bus[7:3];
                        state                    <= after_icw2;
                    end
`ifdef CASCADE_MODE_EN
                    ST_WAIT_ICW3: begin
                        state <= ic4 ? ST_WAIT_ICW4 : ST_READY;
                    end
`endif
                    ST_WAIT_ICW4: begin
                        special_fully_nested     <= internal_data_bus[ICW4_SFNM];
                        buffered_mode            <= internal_data_bus[ICW4_BUF];
                        buffered_master_or_slave <= internal_data_bus[ICW4_MS];
                        auto_eoi                 <= internal_data_bus[ICW4_AEOI];
                        u8086_or_mcs80           <= internal_data_bus[ICW4_UPM];
                        state                    <= ST_READY;
                    end
                    ST_READY: begin
                        interrupt_mask <= internal_data_bus;
                    end
                    default: begin
                    end
                endcase
            end else if (do_ocw2 && state == ST_READY) begin
                ocw2_strobe  <= 1'b1;
                ocw2_command <= internal_data_bus;
            end else if (do_ocw3 && state == ST_READY) begin
                if (internal_data_bus[OCW3_ESMM]) begin
                    special_mask_mode <= internal_data_bus[OCW3_SMM];
                end
                if (internal_data_bus[OCW3_RR]) begin
                    read_register_isr_or_irr <= internal_data_bus[OCW3_RIS];
                end
            end
        end
    end

`ifdef CASCADE_MODE_EN
    logic [7:0] icw3_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            icw3_q <= ICW3_RESET_VALUE;
        end else if (do_a0 && state == ST_WAIT_ICW3) begin
            icw3_q <= internal_data_bus;
        end
    end

    assign cascade_device_config = icw3_q;
`else
    assign cascade_device_config = ICW3_RESET_VALUE;
`endif

    assign init_done = (state == ST_READY);

endmodule

// File: doc/control_word_sequencer.md
Name: control_word_sequencer

Overview:
Clocked controller between the 8259A bus control logic and the interrupt datapath. It sequences the ICW1→ICW2→(ICW3)→(ICW4) initialization protocol and routes OCW1/OCW2/OCW3 writes. It holds all configuration registers: vector base, trigger mode, mask, read-register select, special mask mode and ICW4 modes. It also issues one-cycle OCW2 command pulses to the priority/in-service logic.

Parameters:
IMR_RESET_VALUE, 8'h00, interrupt_mask value on reset and on every ICW1
ICW3_RESET_VALUE, 8'h00, cascade_device_config value on reset

Ports:
clock  input  1  system clock
reset  input  1  asynchronous, active-high reset
internal_data_bus  input  8  write data from bus control logic
write_initial_command_word_1  input  1  level strobe, A0=0 with D4=1
write_a0_high  input  1  level strobe, any A0=1 write (ICW2/3/4 or OCW1)
write_operation_control_word_2  input  1  level strobe, A0=0, D4=0, D3=0
write_operation_control_word_3  input  1  level strobe, A0=0, D4=0, D3=1
init_done  output  1  initialization complete (state READY)
level_or_edge_triggered  output  1  ICW1 D3 (LTIM)
call_address_interval_4  output  1  ICW1 D2 (ADI)
single_or_cascade  output  1  ICW1 D1 (SNGL)
interrupt_vector_address  output  5  ICW2 D7..D3
cascade_device_config  output  8  ICW3
special_fully_nested  output  1  ICW4 D4
buffered_mode  output  1  ICW4 D3
buffered_master_or_slave  output  1  ICW4 D2
auto_eoi  output  1  ICW4 D1
u8086_or_mcs80  output  1  ICW4 D0
interrupt_mask  output  8  OCW1
special_mask_mode  output  1  OCW3 SMM latch
read_register_isr_or_irr  output  1  1 selects ISR, 0 selects IRR
ocw2_strobe  output  1  one-cycle pulse per OCW2 write
ocw2_command  output  8  OCW2 byte, valid while ocw2_strobe=1

Behaviour:
- Reset (async, active-high): state=UNINIT. All outputs 0, except interrupt_mask=IMR_RESET_VALUE and cascade_device_config=ICW3_RESET_VALUE.
- Strobes are level inputs. Each strobe is registered once (strobe_q). An event is strobe & ~strobe_q. A strobe held for N cycles produces exactly one event.
- Latency: register and state updates occur on the clock edge where the event is detected. Outputs are visible the following cycle. ocw2_strobe is high for exactly that one cycle.
- Event priority within a cycle: ICW1 > A0-high > OCW2 > OCW3. Lower-priority events in the same cycle are dropped.
- States: UNINIT, WAIT_ICW2, WAIT_ICW3, WAIT_ICW4, READY.
- ICW1 event, from any state:
  - Latch LTIM/ADI/SNGL and the IC4 flag.
  - interrupt_mask=IMR_RESET_VALUE, special_mask_mode=0, read_register_isr_or_irr=0.
  - Clear all ICW4 outputs.
  - init_done=0, next state WAIT_ICW2.
- A0-high event:
  - WAIT_ICW2: latch D7..D3 into the vector. Next state is WAIT_ICW3 if SNGL=0, else WAIT_ICW4 if IC4=1, else READY.
  - WAIT_ICW3: latch ICW3. Next state is WAIT_ICW4 if IC4=1, else READY.
  - WAIT_ICW4: latch D4..D0. Next state READY.
  - READY: OCW1, interrupt_mask=data.
  - UNINIT: ignored.
- OCW2 event: acted on only in READY; ignored in any other state. Drives ocw2_strobe=1 and ocw2_command=data for one cycle. ocw2_command returns to 0 afterwards.
- OCW3 event: acted on only in READY; ignored in any other state.
  - If D6 (ESMM)=1, special_mask_mode=D5.
  - If D1 (RR)=1, read_register_isr_or_irr=D0.
  - Otherwise both fields hold their values.
- init_done=1 exactly in READY.

Optional Feature:
CASCADE_MODE_EN
- Defined: WAIT_ICW3 exists and SNGL=0 consumes ICW3 as above.
- Undefined: WAIT_ICW3 is removed and the sequence after ICW2 ignores SNGL. cascade_device_config is tied to ICW3_RESET_VALUE. single_or_cascade still reflects ICW1 D1.

Decomposition:
- Package pic_control_pkg holds:
  - the state enum;
  - bit-position constants for ICW1 (LTIM=3, ADI=2, SNGL=1, IC4=0), ICW4 (SFNM=4, BUF=3, MS=2, AEOI=1, uPM=0) and OCW3 (ESMM=6, SMM=5, RR=1, RIS=0).
- One sub-module: write_strobe_edge_detector. It is a registered rising-edge detector, instantiated once per strobe.

Test Plan:
- Single mode with ICW4: ICW1=0x13, ICW2=0x20, ICW4=0x03 → WAIT_ICW3 skipped, interrupt_vector_address=5'b00100, auto_eoi=1, u8086_or_mcs80=1, init_done=1 after the third write.
- Cascade mode: ICW1=0x11, ICW2=0x40, ICW3=0x04, ICW4=0x01 → cascade_device_config=0x04, single_or_cascade=0, init_done=1. Without CASCADE_MODE_EN: 0x04 lands as ICW4 and cascade_device_config stays 0x00.
- No ICW4: ICW1=0x12, ICW2=0x08 → READY, all ICW4 outputs 0. Then A0-high write 0xFB → interrupt_mask=0xFB.
- OCW2/OCW3 in READY: OCW3=0x0B → read_register_isr_or_irr=1. OCW3=0x68 → special_mask_mode=1. OCW2=0x20 → ocw2_strobe high exactly 1 cycle with ocw2_command=0x20.
- Robustness:
  - A strobe held 5 cycles produces one event.
  - OCW1 or OCW2 before init is ignored.
  - A new ICW1 mid-sequence (in WAIT_ICW4) restarts at WAIT_ICW2 with the mask reset.
  - Async reset asserted mid-cycle forces UNINIT and interrupt_mask=IMR_RESET_VALUE immediately.
